// File: rtl/game_pkg.sv
// Shared types and helpers for the game round timer: state encoding, digit width,
// default prescaler length and BCD helper functions.
package game_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int unsigned DIGIT_W               = 4;
  localparam int unsigned DEFAULT_TICKS_PER_SEC = 100000000;

  // Elaboration-time conversion of a 0..99 constant by repeated subtraction.
  function automatic logic [2*DIGIT_W-1:0] to_bcd(input int unsigned value);
    int unsigned rem;
    logic [DIGIT_W-1:0] tens;
    rem  = value;
    tens = 4'd0;
    for (int i = 0; i < 10; i++) begin
      if (rem >= 32'd10) begin
        rem  = rem - 32'd10;
        tens = tens + 4'd1;
      end else begin
        rem = rem;
      end
    end
    return {tens, rem[DIGIT_W-1:0]};
  endfunction

  // One-second BCD decrement with borrow from the tens digit.
  function automatic logic [2*DIGIT_W-1:0] bcd_dec(input logic [2*DIGIT_W-1:0] digits);
    logic [DIGIT_W-1:0] tens;
    logic [DIGIT_W-1:0] ones;
    tens = digits[2*DIGIT_W-1:DIGIT_W];
    ones = digits[DIGIT_W-1:0];
    if (ones == 4'd0) begin
      ones = 4'd9;
      tens = (tens == 4'd0) ? 4'd0 : tens - 4'd1;
    end else begin
      ones = ones - 4'd1;
    end
    return {tens, ones};
  endfunction

  function automatic int unsigned bcd_value(input logic [2*DIGIT_W-1:0] digits);
    return (32'(digits[2*DIGIT_W-1:DIGIT_W]) * 32'd10) + 32'(digits[DIGIT_W-1:0]);
  endfunction

endpackage

// File: rtl/game_round_timer_sec_tick.sv
// sec_tick_gen: prescaler counting 0..TICKS-1 while enabled, emitting a one-cycle tick
// at the terminal count; clear forces it back to zero.
module sec_tick_gen
  import game_pkg::*;
#(
  parameter int unsigned TICKS = DEFAULT_TICKS_PER_SEC
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic tick
);

  localparam int unsigned CNT_W = (TICKS > 32'd1) ? $clog2(TICKS) : 1;
  localparam logic [CNT_W-1:0] TERM = CNT_W'(TICKS - 32'd1);

  logic [CNT_W-1:0] cnt_r;

  assign tick = en & (cnt_r == TERM);

  // Prescaler count, wrapping at the terminal count.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt_r <= '0;
    end else if (en) begin
      cnt_r <= tick ? '0 : cnt_r + CNT_W'(1);
    end else begin
      cnt_r <= cnt_r;
    end
  end

endmodule

// File: rtl/game_round_timer.sv
// Round countdown timer driving two BCD digits, a final-seconds warning and a time-up pulse.
// Optional build macro GAME_TIMER_PAUSE_EN adds a pause input that stalls the countdown.
module game_round_timer
  import game_pkg::*;
#(
  parameter int unsigned TICKS_PER_SEC = DEFAULT_TICKS_PER_SEC,
  parameter int unsigned ROUND_SECONDS = 60,
  parameter int unsigned WARN_SECONDS  = 10
) (
  input  logic               clk,
  input  logic               game_reset,
  input  logic               game_flag,
`ifdef GAME_TIMER_PAUSE_EN
  input  logic               pause,
`endif
  output logic               round_active,
  output logic [DIGIT_W-1:0] secs_tens,
  output logic [DIGIT_W-1:0] secs_ones,
  output logic               warn,
  output logic               time_up
);

  localparam logic [2*DIGIT_W-1:0] ROUND_BCD  = to_bcd(ROUND_SECONDS);
  localparam logic                 WARN_START = (ROUND_SECONDS <= WARN_SECONDS);

  state_t               state_r;
  logic                 flag_q;
  logic                 start_r;
  logic [2*DIGIT_W-1:0] digits_r;
  logic [2*DIGIT_W-1:0] dec_s;
  logic                 pause_s;
  logic                 tick_s;
  logic                 tick_clr_s;
  logic                 tick_en_s;

`ifdef GAME_TIMER_PAUSE_EN
  assign pause_s = pause;
`else
  assign pause_s = 1'b0;
`endif

  assign tick_clr_s = (state_r != RUN);
  assign tick_en_s  = (state_r == RUN) & ~pause_s;
  assign secs_tens  = digits_r[2*DIGIT_W-1:DIGIT_W];
  assign secs_ones  = digits_r[DIGIT_W-1:0];

  sec_tick_gen #(
    .TICKS(TICKS_PER_SEC)
  ) u_sec_tick (
    .clk (clk),
    .rst (game_reset),
    .clr (tick_clr_s),
    .en  (tick_en_s),
    .tick(tick_s)
  );

  // Next digit value for the current tick.
  always_comb begin
    dec_s = bcd_dec(digits_r);
  end

  // Round FSM; start is a rising edge of game_flag delayed one cycle, abort beats a tick.
  always_ff @(posedge clk) begin
    if (game_reset) begin
      state_r      <= IDLE;
      flag_q       <= 1'b0;
      start_r      <= 1'b0;
      digits_r     <= ROUND_BCD;
      round_active <= 1'b0;
      warn         <= 1'b0;
      time_up      <= 1'b0;
    end else begin
      flag_q  <= game_flag;
      start_r <= game_flag & ~flag_q;
      time_up <= 1'b0;
      case (state_r)
        IDLE: begin
          digits_r <= ROUND_BCD;
          if (start_r) begin
            state_r      <= RUN;
            round_active <= 1'b1;
            warn         <= WARN_START;
          end else begin
            state_r      <= IDLE;
            round_active <= 1'b0;
            warn         <= 1'b0;
          end
        end
        RUN: begin
          if (!game_flag) begin
            state_r      <= IDLE;
            digits_r     <= ROUND_BCD;
            round_active <= 1'b0;
            warn         <= 1'b0;
          end else if (tick_s) begin
            if (digits_r == 8'h01) begin
              state_r      <= DONE;
              digits_r     <= 8'h00;
              round_active <= 1'b0;
              warn         <= 1'b0;
              time_up      <= 1'b1;
            end else begin
              digits_r <= dec_s;
              warn     <= (bcd_value(dec_s) <= WARN_SECONDS);
            end
          end else begin
            digits_r <= digits_r;
          end
        end
        DONE: begin
          round_active <= 1'b0;
          warn         <= 1'b0;
          if (!game_flag) begin
            state_r  <= IDLE;
            digits_r <= ROUND_BCD;
          end else begin
            state_r  <= DONE;
            digits_r <= 8'h00;
          end
        end
        default: begin
          state_r      <= IDLE;
          digits_r     <= ROUND_BCD;
          round_active <= 1'b0;
          warn         <= 1'b0;
        end
      endcase
    end
  end

endmodule
